// File: rtl/fifo_ctrl_32x8_if.sv
// Request/status bundle between a FIFO client and the pointer/flag controller.
// The master issues Push/Pop; the slave (controller) drives row selects and flags.
interface fifo_ctrl_32x8_if #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
);
  logic              Push;
  logic              Pop;
  logic [DEPTH-1:0]  Write_Row_Select;
  logic [DEPTH-1:0]  Read_Row_Select;
  logic              Write_Enable;
  logic [ADDR_W:0]   Count;
  logic              Full;
  logic              Empty;
  logic              Almost_Full;
  logic              Almost_Empty;
  logic              Overflow;
  logic              Underflow;

  modport master (
    output Push, Pop,
    input  Write_Row_Select, Read_Row_Select, Write_Enable, Count,
    input  Full, Empty, Almost_Full, Almost_Empty, Overflow, Underflow
  );

  modport slave (
    input  Push, Pop,
    output Write_Row_Select, Read_Row_Select, Write_Enable, Count,
    output Full, Empty, Almost_Full, Almost_Empty, Overflow, Underflow
  );
endinterface

// File: rtl/fifo_ctrl_32x8.sv
// Pointer/flag controller for a 32x8 row-array FIFO: zero-latency one-hot row selects,
// Write_Enable is the only combinational output; rejected pushes/pops set sticky error flags.
module fifo_ctrl_32x8 #(
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 4
) (
  input logic              Clock,
  input logic              Reset_n,
  fifo_ctrl_32x8_if.slave  bus
);

  localparam logic [ADDR_W:0]  AF_THR  = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0]  AE_THR  = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0]  PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [DEPTH-1:0] ROW0    = DEPTH'(1);

  logic [ADDR_W:0] wp_q;
  logic [ADDR_W:0] rp_q;
  logic [ADDR_W:0] count_q;
  logic            ovf_q;
  logic            unf_q;

  logic full;
  logic empty;
  logic push_ok;
  logic pop_ok;

  // Wrap bit distinguishes full (same row, different lap) from empty (same row, same lap).
  assign full  = (wp_q[ADDR_W] != rp_q[ADDR_W]) &&
                 (wp_q[ADDR_W-1:0] == rp_q[ADDR_W-1:0]);
  assign empty = (wp_q == rp_q);

  assign push_ok = bus.Push & ~full;
  assign pop_ok  = bus.Pop  & ~empty;

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (push_ok) wp_q <= wp_q + PTR_ONE;
      if (pop_ok)  rp_q <= rp_q + PTR_ONE;

      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + PTR_ONE;
        2'b01:   count_q <= count_q - PTR_ONE;
        default: count_q <= count_q;
      endcase

      // Pop wins when full and push wins when empty, so the loser is what gets flagged.
      if (bus.Push && full)  ovf_q <= 1'b1;
      if (bus.Pop  && empty) unf_q <= 1'b1;
    end
  end

  assign bus.Write_Enable     = push_ok & Reset_n;
  assign bus.Write_Row_Select = ROW0 << wp_q[ADDR_W-1:0];
  assign bus.Read_Row_Select  = ROW0 << rp_q[ADDR_W-1:0];
  assign bus.Count            = count_q;
  assign bus.Full             = full;
  assign bus.Empty            = empty;
  assign bus.Almost_Full      = (count_q >= AF_THR);
  assign bus.Almost_Empty     = (count_q <= AE_THR);
  assign bus.Overflow         = ovf_q;
  assign bus.Underflow        = unf_q;

  a_count_matches_ptrs: assert property (@(posedge Clock) disable iff (!Reset_n)
    count_q == (wp_q - rp_q));
  a_wsel_onehot: assert property (@(posedge Clock) $onehot(bus.Write_Row_Select));
  a_rsel_onehot: assert property (@(posedge Clock) $onehot(bus.Read_Row_Select));

endmodule
